// File: rtl/kuz_sbox_sched.sv
// Shares one external Kuznyechik S-box between the round datapath (requester 0)
// and the key-expansion unit (requester 1), substituting LANES bytes per cycle.
module kuz_sbox_sched #(
    parameter int LANES = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 req0_valid_i,
    input  logic [127:0]         req0_data_i,
    output logic                 req0_ready_o,
    input  logic                 req1_valid_i,
    input  logic [127:0]         req1_data_i,
    output logic                 req1_ready_o,
    output logic                 rsp_valid_o,
    output logic [127:0]         rsp_data_o,
    output logic                 rsp_id_o,
    input  logic                 rsp_ready_i,
    output logic [8*LANES-1:0]   sbox_in_o,
    input  logic [8*LANES-1:0]   sbox_out_i,
    output logic                 busy_o
);

    localparam int N  = 16 / LANES;
    localparam int LW = 8 * LANES;
    localparam logic [3:0] LAST = 4'(N - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("kuz_sbox_sched: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_last;
    logic [127:0]   r_blk;
    logic [127:0]   r_res;
    logic           r_valid;
    logic           r_id;

    logic           w_idle;
    logic           w_pick1;
    logic           w_ready0;
    logic           w_ready1;
    logic [LW-1:0]  w_sbox_in;

    // r_last names the requester served most recently; the other one wins a tie.
    assign w_idle    = rstn_i && (r_state == IDLE);
    assign w_pick1   = req1_valid_i && (!req0_valid_i || !r_last);
    assign w_ready0  = w_idle && req0_valid_i && !w_pick1;
    assign w_ready1  = w_idle && w_pick1;
    assign w_sbox_in = (r_state == RUN) ? r_blk[32'(r_cnt) * LW +: LW] : '0;

    assign req0_ready_o = w_ready0;
    assign req1_ready_o = w_ready1;
    assign sbox_in_o    = w_sbox_in;
    assign rsp_valid_o  = r_valid;
    assign rsp_data_o   = r_res;
    assign rsp_id_o     = r_id;
    assign busy_o       = (r_state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_blk   <= '0;
            r_res   <= '0;
            r_valid <= 1'b0;
            r_id    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ready0 || w_ready1) begin
                        r_blk   <= w_ready1 ? req1_data_i : req0_data_i;
                        r_id    <= w_ready1;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res[32'(r_cnt) * LW +: LW] <= sbox_out_i;
                    if (r_cnt == LAST) begin
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        r_last  <= r_id;
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kuz_sbox_sched.sv
// Directed bench for kuz_sbox_sched: a LANES=1 instance covers arbitration, stall
// and reset behaviour; a LANES=4 instance covers the wide-lane latency.
module tb_kuz_sbox_sched;

    localparam logic [127:0] ZERO_RSP = {16{8'hfc}};
    localparam logic [127:0] CNT_IN   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] CNT_RSP  = 128'h4d04c523dafac4fb16316ecf11ddeefc;
    localparam logic [127:0] FF_IN    = {16{8'hff}};
    localparam logic [127:0] FF_RSP   = {16{8'hb6}};

    logic         clk;
    logic         rstn;
    logic         req0Valid, req1Valid, rspReady;
    logic [127:0] req0Data, req1Data;
    logic         ready0, ready1, rspValid, rspId, busy;
    logic [127:0] rspData;
    logic [7:0]   sboxIn, sboxOut;

    logic         req0Valid4, rspReady4;
    logic [127:0] req0Data4;
    logic         ready04, ready14, rspValid4, rspId4, busy4;
    logic [127:0] rspData4;
    logic [31:0]  sboxIn4, sboxOut4;

    int compareCount = 0;
    int errCount     = 0;
    int lat, cyc, lastAcc, gnt;
    bit found, bothHigh;

    kuz_sbox_sched #(.LANES(1)) u1 (
        .clk_i(clk), .rstn_i(rstn),
        .req0_valid_i(req0Valid), .req0_data_i(req0Data), .req0_ready_o(ready0),
        .req1_valid_i(req1Valid), .req1_data_i(req1Data), .req1_ready_o(ready1),
        .rsp_valid_o(rspValid), .rsp_data_o(rspData), .rsp_id_o(rspId), .rsp_ready_i(rspReady),
        .sbox_in_o(sboxIn), .sbox_out_i(sboxOut), .busy_o(busy)
    );

    kuz_sbox_sched #(.LANES(4)) u4 (
        .clk_i(clk), .rstn_i(rstn),
        .req0_valid_i(req0Valid4), .req0_data_i(req0Data4), .req0_ready_o(ready04),
        .req1_valid_i(1'b0), .req1_data_i(128'd0), .req1_ready_o(ready14),
        .rsp_valid_o(rspValid4), .rsp_data_o(rspData4), .rsp_id_o(rspId4), .rsp_ready_i(rspReady4),
        .sbox_in_o(sboxIn4), .sbox_out_i(sboxOut4), .busy_o(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only the byte values the directed vectors use are tabulated; anything else
    // returns X so a wrongly selected byte shows up in the result compare.
    function automatic logic [7:0] sboxModel(input logic [7:0] x);
        case (x)
            8'h00: return 8'hfc;  8'h01: return 8'hee;  8'h02: return 8'hdd;  8'h03: return 8'h11;
            8'h04: return 8'hcf;  8'h05: return 8'h6e;  8'h06: return 8'h31;  8'h07: return 8'h16;
            8'h08: return 8'hfb;  8'h09: return 8'hc4;  8'h0a: return 8'hfa;  8'h0b: return 8'hda;
            8'h0c: return 8'h23;  8'h0d: return 8'hc5;  8'h0e: return 8'h04;  8'h0f: return 8'h4d;
            8'hff: return 8'hb6;
            default: return 8'hxx;
        endcase
    endfunction

    always_comb begin
        sboxOut = sboxModel(sboxIn);
        sboxOut4 = '0;
        for (int j = 0; j < 4; j++) sboxOut4[8*j +: 8] = sboxModel(sboxIn4[8*j +: 8]);
    end

    task automatic applyStimulus(input logic v0, input logic [127:0] d0,
                                 input logic v1, input logic [127:0] d1, input logic rr);
        req0Valid = v0;
        req0Data  = d0;
        req1Valid = v1;
        req1Data  = d1;
        rspReady  = rr;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Steps cycles until rsp_valid_o is seen; latency counts from the accept cycle.
    task automatic waitRsp(input bit dropValid, output int latency);
        latency = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1 && dropValid) begin
                req0Valid = 1'b0;
                req1Valid = 1'b0;
            end
            #1;
            if (rspValid) begin
                latency = i;
                break;
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        applyStimulus(1'b1, '0, 1'b0, '0, 1'b1);
        req0Valid4 = 1'b0;
        req0Data4  = '0;
        rspReady4  = 1'b1;

        // Reset state, with a request already pending
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_rsp_valid", 128'(rspValid), 128'(0));
        checkOutput("rst_rsp_data",  rspData, '0);
        checkOutput("rst_rsp_id",    128'(rspId), 128'(0));
        checkOutput("rst_busy",      128'(busy), 128'(0));
        checkOutput("rst_sbox_in",   128'(sboxIn), 128'(0));
        checkOutput("rst_ready0",    128'(ready0), 128'(0));
        checkOutput("rst_ready1",    128'(ready1), 128'(0));

        // All-zero block from requester 0
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("zero_ready0", 128'(ready0), 128'(1));
        checkOutput("zero_ready1", 128'(ready1), 128'(0));
        waitRsp(1'b1, lat);
        checkOutput("zero_latency", 128'(lat), 128'(17));
        checkOutput("zero_data",    rspData, ZERO_RSP);
        checkOutput("zero_id",      128'(rspId), 128'(0));
        checkOutput("zero_busy",    128'(busy), 128'(1));
        @(negedge clk);
        #1;
        checkOutput("zero_after_valid", 128'(rspValid), 128'(0));
        checkOutput("zero_after_busy",  128'(busy), 128'(0));

        // Counting block from requester 1
        applyStimulus(1'b0, '0, 1'b1, CNT_IN, 1'b1);
        #1;
        checkOutput("cnt_ready1",      128'(ready1), 128'(1));
        checkOutput("cnt_ready0",      128'(ready0), 128'(0));
        checkOutput("cnt_sbox_before", 128'(sboxIn), 128'(0));
        waitRsp(1'b1, lat);
        checkOutput("cnt_latency", 128'(lat), 128'(17));
        checkOutput("cnt_data",    rspData, CNT_RSP);
        checkOutput("cnt_id",      128'(rspId), 128'(1));
        checkOutput("cnt_sbox_done", 128'(sboxIn), 128'(0));
        @(negedge clk);
        #1;
        checkOutput("cnt_sbox_after", 128'(sboxIn), 128'(0));

        // Both requesters valid: grants must alternate, one block per 18 cycles
        applyStimulus(1'b1, '0, 1'b1, CNT_IN, 1'b1);
        #1;
        cyc = 0;
        lastAcc = 0;
        for (int b = 0; b < 6; b++) begin
            found = 1'b0;
            bothHigh = 1'b0;
            gnt = -1;
            for (int i = 0; i < 40 && !found; i++) begin
                if (ready0 && ready1) bothHigh = 1'b1;
                if (ready0 || ready1) begin
                    found = 1'b1;
                    gnt = ready1 ? 1 : 0;
                end else begin
                    @(negedge clk);
                    #1;
                    cyc++;
                end
            end
            checkOutput($sformatf("rr_found_%0d", b), 128'(found), 128'(1));
            checkOutput($sformatf("rr_grant_%0d", b), 128'(gnt), 128'(b % 2));
            checkOutput($sformatf("rr_loser_low_%0d", b), 128'(bothHigh), 128'(0));
            if (b > 0) checkOutput($sformatf("rr_period_%0d", b), 128'(cyc - lastAcc), 128'(18));
            lastAcc = cyc;
            if (b < 5) begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        waitRsp(1'b1, lat);
        checkOutput("rr_last_latency", 128'(lat), 128'(17));
        checkOutput("rr_last_id",      128'(rspId), 128'(1));
        checkOutput("rr_last_data",    rspData, CNT_RSP);

        // Response stalled for 5 cycles with requester 0 waiting
        @(negedge clk);
        applyStimulus(1'b1, CNT_IN, 1'b0, '0, 1'b0);
        #1;
        checkOutput("stall_accept", 128'(ready0), 128'(1));
        waitRsp(1'b0, lat);
        checkOutput("stall_latency", 128'(lat), 128'(17));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            checkOutput($sformatf("stall_data_%0d", i),   rspData, CNT_RSP);
            checkOutput($sformatf("stall_id_%0d", i),     128'(rspId), 128'(0));
            checkOutput($sformatf("stall_busy_%0d", i),   128'(busy), 128'(1));
            checkOutput($sformatf("stall_ready0_%0d", i), 128'(ready0), 128'(0));
            checkOutput($sformatf("stall_valid_%0d", i),  128'(rspValid), 128'(1));
        end
        @(negedge clk);
        rspReady = 1'b1;
        #1;
        checkOutput("stall_hs_valid",  128'(rspValid), 128'(1));
        checkOutput("stall_hs_ready0", 128'(ready0), 128'(0));
        @(negedge clk);
        #1;
        checkOutput("stall_next_ready0", 128'(ready0), 128'(1));
        checkOutput("stall_next_valid",  128'(rspValid), 128'(0));

        // Reset pulse at RUN counter 7 with a new block pending
        @(negedge clk);
        req0Data = FF_IN;
        repeat (7) @(negedge clk);
        #1;
        checkOutput("midrst_sbox_c7", 128'(sboxIn), 128'(8'h07));
        rstn = 1'b0;
        #1;
        checkOutput("midrst_ready0_low", 128'(ready0), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("midrst_valid",  128'(rspValid), 128'(0));
        checkOutput("midrst_data",   rspData, '0);
        checkOutput("midrst_id",     128'(rspId), 128'(0));
        checkOutput("midrst_busy",   128'(busy), 128'(0));
        checkOutput("midrst_sbox",   128'(sboxIn), 128'(0));
        checkOutput("midrst_ready0", 128'(ready0), 128'(1));
        waitRsp(1'b1, lat);
        checkOutput("midrst_latency", 128'(lat), 128'(17));
        checkOutput("midrst_rsp_data", rspData, FF_RSP);
        checkOutput("midrst_rsp_id",   128'(rspId), 128'(0));
        @(negedge clk);
        #1;

        // LANES=4 instance, all-0xff block
        req0Valid4 = 1'b1;
        req0Data4  = FF_IN;
        #1;
        checkOutput("l4_ready0", 128'(ready04), 128'(1));
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) req0Valid4 = 1'b0;
            #1;
            if (i <= 4) checkOutput($sformatf("l4_sbox_in_%0d", i), 128'(sboxIn4), 128'(32'hffffffff));
            if (rspValid4) begin
                lat = i;
                break;
            end
        end
        checkOutput("l4_latency", 128'(lat), 128'(5));
        checkOutput("l4_data",    rspData4, FF_RSP);
        checkOutput("l4_id",      128'(rspId4), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
        $finish;
    end

endmodule
